// File: rtl/poly_gen_pkg.sv
// Shared types, default geometry and feedback function for the poly_gen noise block.
package poly_gen_pkg;

    typedef enum logic [1:0] {
        ADV_IDLE = 2'd0,
        ADV_RUN  = 2'd1,
        ADV_DONE = 2'd2
    } adv_state_t;

    localparam int DEF_LEN_A = 4;
    localparam int DEF_TAP_A = 1;
    localparam int DEF_LEN_B = 5;
    localparam int DEF_TAP_B = 2;
    localparam int DEF_LEN_S = 9;
    localparam int DEF_LEN_L = 17;
    localparam int DEF_TAP_L = 5;
    localparam int DEF_RND_W = 8;
    localparam int DEF_CNT_W = 16;

    // XNOR feedback keeps all-zero as a legal state; all-ones is the lockup.
    function automatic logic xnor_fb(input logic i_b0, input logic i_bt);
        return ~(i_b0 ^ i_bt);
    endfunction

endpackage

// File: rtl/poly_gen_if.sv
// Control/status bundle between the poly_gen block and its host.
interface poly_gen_if #(
    parameter int LEN_L = 17,
    parameter int CNT_W = 16,
    parameter int RND_W = 8
);
    logic             step_en;
    logic             init;
    logic             sel_short;
    logic             seed_valid;
    logic             seed_ready;
    logic [LEN_L-1:0] seed_data;
    logic             adv_req;
    logic [CNT_W-1:0] adv_cnt;
    logic             adv_busy;
    logic             adv_done;
    logic             poly_a;
    logic             poly_b;
    logic             poly_l;
    logic [RND_W-1:0] rnd_num;

    modport master (
        output step_en, init, sel_short, seed_valid, seed_data, adv_req, adv_cnt,
        input  seed_ready, adv_busy, adv_done, poly_a, poly_b, poly_l, rnd_num
    );

    modport slave (
        input  step_en, init, sel_short, seed_valid, seed_data, adv_req, adv_cnt,
        output seed_ready, adv_busy, adv_done, poly_a, poly_b, poly_l, rnd_num
    );
endinterface

// File: rtl/poly_gen_lfsr.sv
// Fixed-length Fibonacci XNOR LFSR used for the short polys; q is the output bit 0.
module xnor_lfsr
    import poly_gen_pkg::*;
#(
    parameter int LEN = 4,
    parameter int TAP = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic step,
    input  logic clr,
    output logic q
);
    logic [LEN-1:0] r_q;
    logic           w_fb;

    assign w_fb = xnor_fb(r_q[0], r_q[TAP]);
    assign q    = r_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (step) begin
            r_q <= {w_fb, r_q[LEN-1:1]};
        end
    end
endmodule

// File: rtl/poly_gen.sv
// Polynomial noise generator: two short LFSRs plus a dual-length long LFSR with seed load.
// Define POLY_GEN_ADVANCE_EN to build the burst-advance FSM that skips the long poly ahead.
module poly_gen
    import poly_gen_pkg::*;
#(
    parameter int LEN_A = DEF_LEN_A,
    parameter int TAP_A = DEF_TAP_A,
    parameter int LEN_B = DEF_LEN_B,
    parameter int TAP_B = DEF_TAP_B,
    parameter int LEN_S = DEF_LEN_S,
    parameter int LEN_L = DEF_LEN_L,
    parameter int TAP_L = DEF_TAP_L,
    parameter int RND_W = DEF_RND_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic        clk,
    input logic        rst_n,
    poly_gen_if.slave  bus
);
    localparam logic [LEN_L-1:0] SHORT_MASK = {{(LEN_L-LEN_S){1'b0}}, {LEN_S{1'b1}}};

    logic [LEN_L-1:0] r_long;
    logic             r_mode;
    logic             w_fb;
    logic [LEN_L-1:0] w_long_next;
    logic [LEN_L-1:0] w_seed_img;
    logic             w_seed_load;
    logic             w_adv_step;
    logic             w_adv_busy;
    logic             w_adv_done;

    xnor_lfsr #(.LEN(LEN_A), .TAP(TAP_A)) u_lfsr_a (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (bus.step_en),
        .clr   (bus.init),
        .q     (bus.poly_a)
    );

    xnor_lfsr #(.LEN(LEN_B), .TAP(TAP_B)) u_lfsr_b (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (bus.step_en),
        .clr   (bus.init),
        .q     (bus.poly_b)
    );

    assign w_fb = xnor_fb(r_long[0], r_long[TAP_L]);

    // Short mode injects at LEN_S-1 and flushes everything above it to zero.
    always_comb begin
        w_long_next = {w_fb, r_long[LEN_L-1:1]};
        if (r_mode) begin
            w_long_next            = '0;
            w_long_next[LEN_S-1]   = w_fb;
            w_long_next[LEN_S-2:0] = r_long[LEN_S-1:1];
        end
    end

    always_comb begin
        w_seed_img = bus.seed_data;
        if (r_mode) begin
            w_seed_img = bus.seed_data & SHORT_MASK;
        end
        if (r_mode ? (&bus.seed_data[LEN_S-1:0]) : (&bus.seed_data)) begin
            w_seed_img[0] = 1'b0;
        end
    end

`ifdef POLY_GEN_ADVANCE_EN
    adv_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ADV_IDLE;
            r_cnt   <= '0;
        end else if (bus.init) begin
            r_state <= ADV_IDLE;
        end else begin
            case (r_state)
                ADV_IDLE: begin
                    if (bus.adv_req) begin
                        if (bus.adv_cnt != '0) begin
                            r_cnt   <= bus.adv_cnt;
                            r_state <= ADV_RUN;
                        end else begin
                            r_state <= ADV_DONE;
                        end
                    end
                end
                ADV_RUN: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ADV_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ADV_DONE: r_state <= ADV_IDLE;
                default:  r_state <= ADV_IDLE;
            endcase
        end
    end

    assign w_adv_step = (r_state == ADV_RUN);
    assign w_adv_busy = (r_state == ADV_RUN);
    assign w_adv_done = (r_state == ADV_DONE);
`else
    logic w_unused_adv;

    assign w_unused_adv = ^{bus.adv_req, bus.adv_cnt};
    assign w_adv_step   = 1'b0;
    assign w_adv_busy   = 1'b0;
    assign w_adv_done   = 1'b0;
`endif

    assign bus.seed_ready = ~bus.init & ~w_adv_busy;
    assign w_seed_load    = bus.seed_valid & bus.seed_ready;

    // During an advance the long poly steps once per clock no matter what step_en does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_long <= '0;
            r_mode <= 1'b0;
        end else if (bus.init) begin
            r_long <= '0;
            r_mode <= 1'b0;
        end else if (w_seed_load) begin
            r_long <= w_seed_img;
        end else if (w_adv_step | bus.step_en) begin
            r_long <= w_long_next;
            r_mode <= bus.sel_short;
        end
    end

    assign bus.poly_l   = r_long[0];
    assign bus.rnd_num  = ~r_long[RND_W-1:0];
    assign bus.adv_busy = w_adv_busy;
    assign bus.adv_done = w_adv_done;
endmodule

// File: tb/tb_poly_gen.sv
// Scoreboard bench for poly_gen at default geometry; honours POLY_GEN_ADVANCE_EN.
module tb_poly_gen;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    poly_gen_if #(.LEN_L(17), .CNT_W(16), .RND_W(8)) bus ();

    poly_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        a;
        logic        b;
        logic [16:0] l;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  m_a;
    logic [4:0]  m_b;
    logic [16:0] m_l;
    logic        m_mode;

    function automatic logic [3:0] ref_a(input logic [3:0] s);
        return {~(s[0] ^ s[1]), s[3:1]};
    endfunction

    function automatic logic [4:0] ref_b(input logic [4:0] s);
        return {~(s[0] ^ s[2]), s[4:1]};
    endfunction

    function automatic logic [16:0] ref_long(input logic [16:0] s, input logic short_m);
        logic fb;
        fb = ~(s[0] ^ s[5]);
        if (short_m) return {8'h00, fb, s[8:1]};
        return {fb, s[16:1]};
    endfunction

    // Predict the effect of the upcoming edge from the inputs now on the bus.
    task automatic model_cycle(input bit adv_step);
        logic [16:0] sd;
        exp_t        e;
        if (bus.init) begin
            m_a = '0; m_b = '0; m_l = '0; m_mode = 1'b0;
        end else begin
            if (bus.step_en) begin
                m_a = ref_a(m_a);
                m_b = ref_b(m_b);
            end
            if (bus.seed_valid && !adv_step) begin
                sd = m_mode ? (bus.seed_data & 17'h001FF) : bus.seed_data;
                if (m_mode ? (sd[8:0] == 9'h1FF) : (sd == 17'h1FFFF)) sd[0] = 1'b0;
                m_l = sd;
            end else if (adv_step || bus.step_en) begin
                m_l    = ref_long(m_l, m_mode);
                m_mode = bus.sel_short;
            end
        end
        e.a = m_a[0]; e.b = m_b[0]; e.l = m_l;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [13:0] got;
        rst_n = 1'b0;
        repeat (2) tick();
        got = {bus.poly_a, bus.poly_b, bus.poly_l, bus.rnd_num, bus.seed_ready, bus.adv_busy, bus.adv_done};
        checks++;
        if (got !== 14'b000_11111111_100) begin
            errors++;
            $display("FAIL reset_hold: outputs %b, required %b", got, 14'b000_11111111_100);
        end
        rst_n = 1'b1;
        tick();
        got = {bus.poly_a, bus.poly_b, bus.poly_l, bus.rnd_num, bus.seed_ready, bus.adv_busy, bus.adv_done};
        checks++;
        if (got !== 14'b000_11111111_100) begin
            errors++;
            $display("FAIL reset_release: outputs %b, required %b", got, 14'b000_11111111_100);
        end
        checks++;
        if (bus.rnd_num !== 8'hFF) begin
            errors++;
            $display("FAIL reset_rnd: rnd_num %h, required ff", bus.rnd_num);
        end
        m_a = '0; m_b = '0; m_l = '0; m_mode = 1'b0;
        sb.delete();
    endtask

    task automatic test_short_polys();
        logic ha[0:69];
        logic hb[0:69];
        exp_t e;
        logic [18:0] got, fgot, fexp;
        int nbad;
        bit ok15, n3, n5, ok31, n1;
        nbad = 0; fgot = '0; fexp = '0;
        bus.step_en = 1'b1; bus.sel_short = 1'b0;
        for (int k = 0; k < 70; k++) begin
            model_cycle(1'b0);
            tick();
            e = sb.pop_front();
            got = {bus.poly_a, bus.poly_b, dut.r_long};
            if (got !== e) begin
                if (nbad == 0) begin fgot = got; fexp = e; end
                nbad++;
            end
            ha[k] = bus.poly_a;
            hb[k] = bus.poly_b;
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL short_polys_model: %0d bad steps, first got %h want %h", nbad, fgot, fexp);
        end
        ok15 = 1'b1; n3 = 1'b0; n5 = 1'b0; ok31 = 1'b1; n1 = 1'b0;
        for (int i = 15; i < 70; i++) if (ha[i] !== ha[i-15]) ok15 = 1'b0;
        for (int i = 5; i < 70; i++) begin
            if (ha[i] !== ha[i-3]) n3 = 1'b1;
            if (ha[i] !== ha[i-5]) n5 = 1'b1;
        end
        for (int i = 31; i < 70; i++) if (hb[i] !== hb[i-31]) ok31 = 1'b0;
        for (int i = 1; i < 70; i++) if (hb[i] !== hb[i-1]) n1 = 1'b1;
        checks++;
        if (!(ok15 && n3 && n5)) begin
            errors++;
            $display("FAIL poly_a_period: p15=%0b not3=%0b not5=%0b, required 1 1 1", ok15, n3, n5);
        end
        checks++;
        if (!(ok31 && n1)) begin
            errors++;
            $display("FAIL poly_b_period: p31=%0b nonconst=%0b, required 1 1", ok31, n1);
        end
        bus.step_en = 1'b0;
    endtask

    task automatic test_long_modes();
        exp_t e;
        logic [18:0] got, fgot, fexp;
        logic [16:0] cap;
        int nbad, lock, ret;
        // short mode
        bus.init = 1'b1; model_cycle(1'b0); tick(); void'(sb.pop_front()); bus.init = 1'b0;
        bus.sel_short = 1'b1; bus.step_en = 1'b1;
        nbad = 0; lock = 0; ret = 0; cap = '0; fgot = '0; fexp = '0;
        for (int k = 1; k <= 1100; k++) begin
            model_cycle(1'b0);
            tick();
            e = sb.pop_front();
            got = {bus.poly_a, bus.poly_b, dut.r_long};
            if (got !== e) begin
                if (nbad == 0) begin fgot = got; fexp = e; end
                nbad++;
            end
            if (dut.r_long[8:0] === 9'h1FF) lock++;
            if (k == 20) cap = dut.r_long;
            else if (k > 20 && ret == 0 && dut.r_long === cap) ret = k - 20;
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL short_mode_model: %0d bad steps, first got %h want %h", nbad, fgot, fexp);
        end
        checks++;
        if (ret != 511) begin
            errors++;
            $display("FAIL short_mode_period: got %0d, required 511", ret);
        end
        checks++;
        if (lock != 0) begin
            errors++;
            $display("FAIL short_mode_lockup: all-ones seen %0d times, required 0", lock);
        end
        // long mode
        bus.init = 1'b1; model_cycle(1'b0); tick(); void'(sb.pop_front()); bus.init = 1'b0;
        bus.sel_short = 1'b0;
        nbad = 0; lock = 0;
        for (int k = 1; k <= 3000; k++) begin
            model_cycle(1'b0);
            tick();
            e = sb.pop_front();
            got = {bus.poly_a, bus.poly_b, dut.r_long};
            if (got !== e) begin
                if (nbad == 0) begin fgot = got; fexp = e; end
                nbad++;
            end
            if (dut.r_long === 17'h1FFFF) lock++;
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL long_mode_model: %0d bad steps, first got %h want %h", nbad, fgot, fexp);
        end
        checks++;
        if (lock != 0) begin
            errors++;
            $display("FAIL long_mode_lockup: all-ones seen %0d times, required 0", lock);
        end
        bus.step_en = 1'b0;
    endtask

    task automatic test_seed();
        exp_t e;
        logic [18:0] got;
        bus.init = 1'b1; model_cycle(1'b0); tick(); void'(sb.pop_front()); bus.init = 1'b0;
        // all-ones seed in long mode, with step_en suppressed for the long poly
        bus.sel_short = 1'b0; bus.step_en = 1'b1; bus.seed_valid = 1'b1; bus.seed_data = 17'h1FFFF;
        #1;
        checks++;
        if (bus.seed_ready !== 1'b1) begin
            errors++;
            $display("FAIL seed_ready_idle: got %b, required 1", bus.seed_ready);
        end
        model_cycle(1'b0); tick();
        e = sb.pop_front(); got = {bus.poly_a, bus.poly_b, dut.r_long};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL seed_long_model: got %h want %h", got, e);
        end
        checks++;
        if (dut.r_long !== 17'h1FFFE) begin
            errors++;
            $display("FAIL seed_all_ones_long: long %h, required 1fffe", dut.r_long);
        end
        // ordinary seed value
        bus.step_en = 1'b0; bus.seed_data = 17'h0ABCD;
        model_cycle(1'b0); tick(); void'(sb.pop_front());
        checks++;
        if (dut.r_long !== 17'h0ABCD) begin
            errors++;
            $display("FAIL seed_plain: long %h, required 0abcd", dut.r_long);
        end
        // enter short mode, then seed all ones
        bus.seed_valid = 1'b0; bus.sel_short = 1'b1; bus.step_en = 1'b1;
        model_cycle(1'b0); tick(); void'(sb.pop_front());
        bus.step_en = 1'b0; bus.seed_valid = 1'b1; bus.seed_data = 17'h1FFFF;
        model_cycle(1'b0); tick(); void'(sb.pop_front());
        checks++;
        if (dut.r_long !== 17'h001FE) begin
            errors++;
            $display("FAIL seed_all_ones_short: long %h, required 001fe", dut.r_long);
        end
        // seed offered under init
        bus.init = 1'b1; bus.seed_data = 17'h0ABCD;
        #1;
        checks++;
        if (bus.seed_ready !== 1'b0) begin
            errors++;
            $display("FAIL seed_ready_init: got %b, required 0", bus.seed_ready);
        end
        model_cycle(1'b0); tick(); void'(sb.pop_front());
        checks++;
        if (dut.r_long !== 17'h00000) begin
            errors++;
            $display("FAIL seed_under_init: long %h, required 00000", dut.r_long);
        end
        bus.init = 1'b0; bus.seed_valid = 1'b0; bus.sel_short = 1'b0;
    endtask

    task automatic test_mode_toggle();
        exp_t e;
        logic [18:0] got;
        int nbad;
        nbad = 0;
        bus.init = 1'b1; model_cycle(1'b0); tick(); void'(sb.pop_front()); bus.init = 1'b0;
        bus.sel_short = 1'b0; bus.step_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            model_cycle(1'b0); tick();
            e = sb.pop_front(); got = {bus.poly_a, bus.poly_b, dut.r_long};
            if (got !== e) nbad++;
        end
        bus.sel_short = 1'b1;
        model_cycle(1'b0); tick();
        e = sb.pop_front(); got = {bus.poly_a, bus.poly_b, dut.r_long};
        if (got !== e) nbad++;
        checks++;
        if (dut.r_long !== 17'h1E000) begin
            errors++;
            $display("FAIL toggle_delay_long: long %h, required 1e000", dut.r_long);
        end
        model_cycle(1'b0); tick();
        e = sb.pop_front(); got = {bus.poly_a, bus.poly_b, dut.r_long};
        if (got !== e) nbad++;
        checks++;
        if (dut.r_long[16:9] !== 8'h00) begin
            errors++;
            $display("FAIL toggle_upper_clear: long[16:9] %h, required 00", dut.r_long[16:9]);
        end
        bus.sel_short = 1'b0;
        model_cycle(1'b0); tick();
        e = sb.pop_front(); got = {bus.poly_a, bus.poly_b, dut.r_long};
        if (got !== e) nbad++;
        checks++;
        if (dut.r_long[16:9] !== 8'h00) begin
            errors++;
            $display("FAIL toggle_back_delay: long[16:9] %h, required 00", dut.r_long[16:9]);
        end
        model_cycle(1'b0); tick();
        e = sb.pop_front(); got = {bus.poly_a, bus.poly_b, dut.r_long};
        if (got !== e) nbad++;
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL toggle_model: %0d bad steps, required 0", nbad);
        end
        bus.step_en = 1'b0;
    endtask

    task automatic test_advance();
`ifdef POLY_GEN_ADVANCE_EN
        exp_t e;
        logic [18:0] got;
        logic [16:0] ref100;
        int nbad, nbusy, ndone;
        bus.init = 1'b1; model_cycle(1'b0); tick(); void'(sb.pop_front()); bus.init = 1'b0;
        bus.sel_short = 1'b0; bus.seed_valid = 1'b1; bus.seed_data = 17'h00001;
        model_cycle(1'b0); tick(); void'(sb.pop_front());
        bus.seed_valid = 1'b0;
        bus.adv_req = 1'b1; bus.adv_cnt = 16'd100;
        model_cycle(1'b0); tick(); void'(sb.pop_front());
        bus.adv_req = 1'b0; bus.step_en = 1'b1;
        nbad = 0; nbusy = 0; ndone = 0;
        for (int i = 1; i <= 100; i++) begin
            if (bus.adv_busy === 1'b1) nbusy++;
            if (bus.adv_done !== 1'b0) ndone++;
            if (i == 50) begin
                bus.adv_req = 1'b1; bus.adv_cnt = 16'd3; bus.seed_valid = 1'b1; bus.seed_data = 17'h12345;
                #1;
                checks++;
                if (bus.seed_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL seed_ready_busy: got %b, required 0", bus.seed_ready);
                end
            end
            model_cycle(1'b1); tick();
            bus.adv_req = 1'b0; bus.seed_valid = 1'b0;
            e = sb.pop_front(); got = {bus.poly_a, bus.poly_b, dut.r_long};
            if (got !== e) nbad++;
        end
        checks++;
        if (nbusy != 100 || ndone != 0) begin
            errors++;
            $display("FAIL adv_busy_window: busy %0d done %0d, required 100 0", nbusy, ndone);
        end
        checks++;
        if ({bus.adv_busy, bus.adv_done} !== 2'b01) begin
            errors++;
            $display("FAIL adv_done_cycle: busy,done %b, required 01", {bus.adv_busy, bus.adv_done});
        end
        ref100 = 17'h00001;
        for (int i = 0; i < 100; i++) ref100 = ref_long(ref100, 1'b0);
        checks++;
        if (dut.r_long !== ref100 || nbad != 0) begin
            errors++;
            $display("FAIL adv_state: long %h (%0d bad steps), required %h", dut.r_long, nbad, ref100);
        end
        bus.step_en = 1'b0;
        model_cycle(1'b0); tick(); void'(sb.pop_front());
        checks++;
        if ({bus.adv_busy, bus.adv_done} !== 2'b00) begin
            errors++;
            $display("FAIL adv_done_pulse: busy,done %b, required 00", {bus.adv_busy, bus.adv_done});
        end
        // zero count
        bus.adv_req = 1'b1; bus.adv_cnt = 16'd0;
        model_cycle(1'b0); tick(); void'(sb.pop_front());
        bus.adv_req = 1'b0;
        checks++;
        if ({bus.adv_busy, bus.adv_done} !== 2'b01) begin
            errors++;
            $display("FAIL adv_zero: busy,done %b, required 01", {bus.adv_busy, bus.adv_done});
        end
        model_cycle(1'b0); tick(); void'(sb.pop_front());
        // abort with init in cycle 10
        bus.adv_req = 1'b1; bus.adv_cnt = 16'd50;
        model_cycle(1'b0); tick(); void'(sb.pop_front());
        bus.adv_req = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            model_cycle(1'b1); tick(); void'(sb.pop_front());
        end
        checks++;
        if (bus.adv_busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_busy: busy %b, required 1", bus.adv_busy);
        end
        bus.init = 1'b1;
        model_cycle(1'b1); tick();
        bus.init = 1'b0;
        e = sb.pop_front(); got = {bus.poly_a, bus.poly_b, dut.r_long};
        checks++;
        if (bus.adv_busy !== 1'b0 || got !== e) begin
            errors++;
            $display("FAIL abort_clear: busy %b polys %h, required 0 %h", bus.adv_busy, got, e);
        end
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            model_cycle(1'b0); tick(); void'(sb.pop_front());
            if (bus.adv_done !== 1'b0 || bus.adv_busy !== 1'b0 || dut.r_long !== 17'h0) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d bad cycles after abort, required 0", ndone);
        end
`else
        int nbad;
        bus.init = 1'b1; model_cycle(1'b0); tick(); void'(sb.pop_front()); bus.init = 1'b0;
        bus.seed_valid = 1'b1; bus.seed_data = 17'h00001;
        model_cycle(1'b0); tick(); void'(sb.pop_front());
        bus.seed_valid = 1'b0;
        bus.adv_req = 1'b1; bus.adv_cnt = 16'd5;
        nbad = 0;
        for (int i = 0; i < 8; i++) begin
            model_cycle(1'b0); tick(); void'(sb.pop_front());
            bus.adv_req = 1'b0;
            if (bus.adv_busy !== 1'b0 || bus.adv_done !== 1'b0 || bus.seed_ready !== 1'b1 ||
                dut.r_long !== 17'h00001) nbad++;
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL adv_disabled: %0d cycles with activity, required 0", nbad);
        end
`endif
    endtask

    task automatic test_async_reset();
        logic [13:0] got;
        bus.step_en = 1'b1;
`ifdef POLY_GEN_ADVANCE_EN
        bus.step_en = 1'b0; bus.adv_req = 1'b1; bus.adv_cnt = 16'd40;
        tick();
        bus.adv_req = 1'b0;
`endif
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        got = {bus.poly_a, bus.poly_b, bus.poly_l, bus.rnd_num, bus.seed_ready, bus.adv_busy, bus.adv_done};
        checks++;
        if (got !== 14'b000_11111111_100 || dut.r_long !== 17'h0) begin
            errors++;
            $display("FAIL async_reset: outputs %b long %h, required %b 00000", got, dut.r_long, 14'b000_11111111_100);
        end
        bus.step_en = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.step_en    = 1'b0;
        bus.init       = 1'b0;
        bus.sel_short  = 1'b0;
        bus.seed_valid = 1'b0;
        bus.seed_data  = '0;
        bus.adv_req    = 1'b0;
        bus.adv_cnt    = '0;
        test_reset();
        test_short_polys();
        test_long_modes();
        test_seed();
        test_mode_toggle();
        test_advance();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
